// File: rtl/lab72_soc_keycode_in_if.sv
// Avalon-MM slave bus bundle for the keycode input port.
// The CPU side (master) drives address and strobes; the peripheral (slave)
// returns zero-latency read data.
interface lab72_soc_keycode_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/lab72_soc_keycode_in.sv
// Inbound keycode FIFO on the Avalon-MM peripheral bus.
// Hardware pushes keycodes with a one-cycle in_valid strobe; the CPU pops them
// by reading DATA. STATUS reports count/empty/full and a sticky overflow flag,
// LAST shadows the most recent keycode seen on in_port.
// Optional build macro KEYCODE_IN_IRQ_EN adds the IRQMASK register and the
// level interrupt output irq; without it the CPU polls STATUS.
module lab72_soc_keycode_in #(
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   lab72_soc_keycode_in_if.slave     bus,
   input  logic [7:0]                in_port,
   input  logic                      in_valid
`ifdef KEYCODE_IN_IRQ_EN
   ,
   output logic                      irq
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic [7:0]    last;
   logic [31:0]   rdata;

   logic empty;
   logic full;
   logic rd_data;
   logic wr_status;
   logic flush;
   logic ovf_clr;
   logic pop;
   logic push;
   logic ovf_set;
   logic unused_wd;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign rd_data   = bus.chipselect & ~bus.read_n & (bus.address == 2'd0);
   assign wr_status = bus.chipselect & ~bus.write_n & (bus.address == 2'd1);
   assign flush     = wr_status & bus.writedata[0];
   assign ovf_clr   = wr_status & bus.writedata[10];
   // A flush empties the queue, so any pop in that cycle is moot.
   assign pop       = rd_data & ~empty & ~flush;
   // A pop in the same cycle frees the slot the push needs when full.
   assign push      = in_valid & (~full | pop) & ~flush;
   assign ovf_set   = in_valid & full & ~pop & ~flush;
   assign unused_wd = ^{bus.writedata[31:11], bus.writedata[9:1]};

   // Keycode storage; contents carry no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_port;
   end

   // FIFO pointers, occupancy, sticky overflow and last-key shadow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         last  <= 8'h00;
      end else begin
         if (in_valid) last <= in_port;
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

`ifdef KEYCODE_IN_IRQ_EN
   logic [1:0] mask;

   // Interrupt enable register at address 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask <= 2'b00;
      end else if (bus.chipselect && !bus.write_n && bus.address == 2'd2) begin
         mask <= bus.writedata[1:0];
      end
   end

   assign irq = (mask[0] & ~empty) | (mask[1] & ovf);
`endif

   // Zero-latency register read mux; unlisted bits read 0.
   always_comb begin
      rdata = '0;
      case (bus.address)
         2'd0: begin
            if (!empty) begin
               rdata[7:0] = mem[rptr];
               rdata[8]   = 1'b1;
            end
         end
         2'd1: begin
            rdata[4:0] = 5'(count);
            rdata[8]   = empty;
            rdata[9]   = full;
            rdata[10]  = ovf;
         end
         2'd2: begin
`ifdef KEYCODE_IN_IRQ_EN
            rdata[1:0] = mask;
`endif
         end
         default: rdata[7:0] = last;
      endcase
   end

   assign bus.readdata = rdata;

endmodule

// File: tb/tb_lab72_soc_keycode_in.sv
module tb_lab72_soc_keycode_in;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_port;
   logic       in_valid;
`ifdef KEYCODE_IN_IRQ_EN
   logic       irq;
`endif

   lab72_soc_keycode_in_if bus ();

   lab72_soc_keycode_in #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .in_port  (in_port),
      .in_valid (in_valid)
`ifdef KEYCODE_IN_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: a plain queue plus flag/shadow variables.
   logic [7:0] q[$];
   logic       m_ovf;
   logic [7:0] m_last;
   logic [1:0] m_mask;

   typedef struct {
      logic [1:0]  addr;
      logic        rd;
      logic        wr;
      logic [31:0] wd;
      logic        iv;
      logic [7:0]  ip;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      int v;
      v = 0;
      case (a)
         2'd0: if (q.size() > 0) v = 256 + int'(q[0]);
         2'd1: v = q.size() + ((q.size() == 0) ? 256 : 0)
                   + ((q.size() == DEPTH) ? 512 : 0) + (m_ovf ? 1024 : 0);
         2'd2: begin
`ifdef KEYCODE_IN_IRQ_EN
            v = int'(m_mask);
`endif
         end
         default: v = int'(m_last);
      endcase
      return 32'(v);
   endfunction

   function automatic logic exp_irq();
      return (m_mask[0] && q.size() > 0) || (m_mask[1] && m_ovf);
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_last = 8'h00;
      m_mask = 2'b00;
   endtask

   task automatic model_update(input logic [1:0] a, input logic rd, input logic wr,
                               input logic [31:0] wd, input logic iv, input logic [7:0] ip);
      logic flush;
      logic ovf_set;
      flush   = wr && a == 2'd1 && wd[0];
      ovf_set = 1'b0;
      if (iv) m_last = ip;
      if (flush) begin
         q.delete();
      end else begin
         if (rd && a == 2'd0 && q.size() > 0) void'(q.pop_front());
         if (iv) begin
            if (q.size() < DEPTH) q.push_back(ip);
            else ovf_set = 1'b1;
         end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (wr && a == 2'd1 && wd[10]) m_ovf = 1'b0;
`ifdef KEYCODE_IN_IRQ_EN
      if (wr && a == 2'd2) m_mask = wd[1:0];
`endif
   endtask

   task automatic idle();
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      in_valid       = 1'b0;
      in_port        = 8'h00;
   endtask

   // One bus cycle, entered and left at the falling edge. readdata is checked
   // before the rising edge, against a given constant or the model.
   task automatic step(input logic [1:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic iv, input logic [7:0] ip,
                       input string name, input logic use_exp, input logic [31:0] expv);
      bus.address    = a;
      bus.chipselect = rd | wr;
      bus.read_n     = ~rd;
      bus.write_n    = ~wr;
      bus.writedata  = wd;
      in_valid       = iv;
      in_port        = ip;
      #1;
      check(name, bus.readdata, use_exp ? expv : exp_rd(a));
`ifdef KEYCODE_IN_IRQ_EN
      check({name, "_irq"}, {31'b0, irq}, {31'b0, exp_irq()});
`endif
      @(posedge clk);
      model_update(a, rd, wr, wd, iv, ip);
      @(negedge clk);
      idle();
   endtask

   task automatic fill(input int n, input int base);
      for (int i = 0; i < n; i++) step(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 8'(base + i), "fill", 1'b0, 32'h0);
   endtask

   initial begin
      int phase_pop;
      logic [1:0]  ra;
      logic        rrd, rwr, riv;
      logic [31:0] rwd;

      vecs[0]  = '{2'd0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h000};
      vecs[1]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h100};
      vecs[2]  = '{2'd2, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h000};
      vecs[3]  = '{2'd3, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h000};
      vecs[4]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 8'h1A, 32'h100};
      vecs[5]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 8'h04, 32'h001};
      vecs[6]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b1, 8'h16, 32'h002};
      vecs[7]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h003};
      vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 8'h00, 32'h11A};
      vecs[9]  = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h002};
      vecs[10] = '{2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 8'h00, 32'h104};
      vecs[11] = '{2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 8'h00, 32'h116};
      vecs[12] = '{2'd0, 1'b1, 1'b0, 32'h0,  1'b0, 8'h00, 32'h000};
      vecs[13] = '{2'd1, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h100};
      vecs[14] = '{2'd3, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h016};
      vecs[15] = '{2'd0, 1'b0, 1'b1, 32'hAB, 1'b1, 8'h77, 32'h000};
      vecs[16] = '{2'd0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 32'h177};

      reset_n = 1'b0;
      idle();
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset values and the basic push/pop sequence.
      for (int i = 0; i < 17; i++)
         step(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].iv, vecs[i].ip,
              $sformatf("vec%0d", i), 1'b1, vecs[i].exp);
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "vec_pop77", 1'b1, 32'h177);

      // Overflow: DEPTH+2 pushes, clear OVF, drain in order.
      fill(DEPTH + 2, 1);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "ovf_status", 1'b1, 32'(DEPTH) | 32'h600);
      step(2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "ovf_last", 1'b1, 32'(DEPTH + 2));
      step(2'd1, 1'b0, 1'b1, 32'h400, 1'b0, 8'h00, "ovf_clr_wr", 1'b1, 32'(DEPTH) | 32'h600);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "ovf_cleared", 1'b1, 32'(DEPTH) | 32'h200);
      for (int i = 1; i <= DEPTH; i++)
         step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "drain", 1'b1, 32'h100 | 32'(i));
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "drained", 1'b1, 32'h100);

      // Push and pop together while full.
      fill(DEPTH, 1);
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h2C, "full_pushpop", 1'b1, 32'h101);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "full_pp_stat", 1'b1, 32'(DEPTH) | 32'h200);
      for (int i = 2; i <= DEPTH; i++)
         step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "pp_drain", 1'b1, 32'h100 | 32'(i));
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "pp_tail", 1'b1, 32'h12C);

      // Push and pop together while empty.
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h42, "empty_pushpop", 1'b1, 32'h000);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "empty_pp_stat", 1'b1, 32'h001);
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "empty_pp_pop", 1'b1, 32'h142);

      // OVF clear vs overflow in the same cycle, then flush with push.
      fill(DEPTH + 1, 8'h60);
      step(2'd1, 1'b0, 1'b1, 32'h400, 1'b1, 8'h99, "clr_vs_set", 1'b1, 32'(DEPTH) | 32'h600);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "set_wins", 1'b1, 32'(DEPTH) | 32'h600);
      step(2'd1, 1'b0, 1'b1, 32'h1, 1'b1, 8'h33, "flush_push", 1'b1, 32'(DEPTH) | 32'h600);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "flush_stat", 1'b1, 32'h500);
      step(2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "flush_last", 1'b1, 32'h033);
      step(2'd1, 1'b0, 1'b1, 32'h400, 1'b0, 8'h00, "clr2", 1'b1, 32'h500);
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "clr2_stat", 1'b1, 32'h100);

`ifdef KEYCODE_IN_IRQ_EN
      step(2'd2, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00, "mask1_wr", 1'b1, 32'h0);
      step(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 8'h05, "mask1_push", 1'b1, 32'h1);
      check("irq_ne_set", {31'b0, irq}, 32'h1);
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "irq_pop", 1'b1, 32'h105);
      check("irq_ne_clr", {31'b0, irq}, 32'h0);
      step(2'd2, 1'b0, 1'b1, 32'h2, 1'b0, 8'h00, "mask2_wr", 1'b1, 32'h1);
      fill(DEPTH + 1, 8'h70);
      check("irq_ovf_set", {31'b0, irq}, 32'h1);
      step(2'd1, 1'b0, 1'b1, 32'h401, 1'b0, 8'h00, "irq_ovf_clr", 1'b1, 32'(DEPTH) | 32'h600);
      check("irq_ovf_clr", {31'b0, irq}, 32'h0);
      step(2'd2, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00, "mask0_wr", 1'b1, 32'h2);
`else
      step(2'd2, 1'b0, 1'b1, 32'h3, 1'b0, 8'h00, "mask_absent_wr", 1'b1, 32'h0);
      step(2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "mask_absent_rd", 1'b1, 32'h0);
`endif

      // Randomized traffic against the model: push-heavy, then pop-heavy.
      for (int n = 0; n < 600; n++) begin
         phase_pop = (n / 150) % 2;
         ra  = 2'($urandom_range(0, 3));
         rrd = ($urandom_range(0, 2) == 0);
         if (phase_pop != 0 && $urandom_range(0, 1) == 0) begin
            ra  = 2'd0;
            rrd = 1'b1;
         end
         rwr = !rrd && ($urandom_range(0, 7) == 0);
         rwd = $urandom & ~32'h401;
         if ($urandom_range(0, 3) == 0) rwd[10] = 1'b1;
         if ($urandom_range(0, 5) == 0) rwd[0] = 1'b1;
         riv = (phase_pop != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
         step(ra, rrd, rwr, rwd, riv, 8'($urandom), "rand", 1'b0, 32'h0);
      end

      // Asynchronous reset in the middle of traffic.
      fill(3, 8'hC0);
      #3;
      reset_n = 1'b0;
      bus.address = 2'd1;
      #1;
      check("areset_status", bus.readdata, 32'h100);
      bus.address = 2'd0;
      #1;
      check("areset_data", bus.readdata, 32'h000);
      bus.address = 2'd3;
      #1;
      check("areset_last", bus.readdata, 32'h000);
      model_reset();
      @(negedge clk);
      idle();
      reset_n = 1'b1;
      step(2'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, "post_rst_stat", 1'b1, 32'h100);
      step(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 8'hE1, "post_rst_mask", 1'b1, 32'h000);
      step(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, "post_rst_data", 1'b1, 32'h1E1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
